// File: rtl/spi_arbiter_if.sv
// Bus bundle between the SPI arbiter, its requesters and the shared SPI engine.
interface spi_arbiter_if #(
    parameter int NREQ = 2
);
    // requester side
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      lock;
    logic [NREQ-1:0]      fast_in;
    logic [32*NREQ-1:0]   tx_in;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic [31:0]          rx_data;
    logic [NREQ-1:0]      cs_n;

    // engine side
    logic                 eng_start;
    logic                 eng_fast;
    logic [31:0]          eng_tx;
    logic                 eng_rdy;
    logic [31:0]          eng_rx;

    // Arbiter view
    modport slave (
        input  req, lock, fast_in, tx_in, eng_rdy, eng_rx,
        output gnt, done, rx_data, cs_n, eng_start, eng_fast, eng_tx
    );

    // Requesters plus engine view
    modport master (
        output req, lock, fast_in, tx_in, eng_rdy, eng_rx,
        input  gnt, done, rx_data, cs_n, eng_start, eng_fast, eng_tx
    );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI transfer engine between NREQ requesters.
// Owns the chip-selects, supports locked multi-transfer ownership and inserts
// a DESEL-cycle deselect gap after every release. All outputs are registered
// and the whole FSM is frozen while enable is low.
module spi_arbiter #(
    parameter int NREQ  = 2,
    parameter int DESEL = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    spi_arbiter_if.slave bus
);
    localparam int OW = (NREQ > 2) ? 2 : 1;
    localparam int CW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OWN,
        S_START,
        S_BUSY,
        S_DONE,
        S_GAP
    } state_t;

    state_t            r_state;
    logic [OW-1:0]     r_owner;
    logic [CW-1:0]     r_gap_cnt;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_done;
    logic [NREQ-1:0]   r_cs_n;
    logic [31:0]       r_rx_data;
    logic [31:0]       r_eng_tx;
    logic              r_eng_start;
    logic              r_eng_fast;

    logic              w_any_req;
    logic [OW-1:0]     w_winner;
    logic [NREQ-1:0]   w_grant;
    logic              w_req_own;
    logic              w_lock_own;
    logic              w_fast_own;
    logic [31:0]       w_tx_sel;

    // Round-robin search beginning one past the last owner
    always_comb begin
        int unsigned v_idx;
        logic [OW-1:0] v_sel;
        w_any_req = 1'b0;
        w_winner  = r_owner;
        v_idx     = 0;
        v_sel     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            v_idx = 32'(r_owner) + 32'd1 + i;
            if (v_idx >= unsigned'(NREQ)) begin
                v_idx = v_idx - unsigned'(NREQ);
            end
            v_sel = v_idx[OW-1:0];
            if (!w_any_req && bus.req[v_sel]) begin
                w_any_req = 1'b1;
                w_winner  = v_sel;
            end
        end
        w_grant = NREQ'(1) << w_winner;
    end

    // Current owner's request, lock, mode and transmit slice
    always_comb begin
        w_req_own  = bus.req[r_owner];
        w_lock_own = bus.lock[r_owner];
        w_fast_own = bus.fast_in[r_owner];
        w_tx_sel   = bus.tx_in[{r_owner, 5'b0} +: 32];
    end

    // Ownership / transfer sequencing FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_owner     <= OW'(NREQ - 1);
            r_gap_cnt   <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_cs_n      <= '1;
            r_rx_data   <= '0;
            r_eng_tx    <= '0;
            r_eng_start <= 1'b0;
            r_eng_fast  <= 1'b0;
        end else if (enable) begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_winner;
                        r_gnt   <= w_grant;
                        r_cs_n  <= ~w_grant;
                        r_state <= S_OWN;
                    end
                end
                S_OWN: begin
                    if (w_req_own) begin
                        r_eng_tx    <= w_tx_sel;
                        r_eng_fast  <= w_fast_own;
                        r_eng_start <= 1'b1;
                        r_state     <= S_START;
                    end else if (!w_lock_own) begin
                        r_gnt     <= '0;
                        r_cs_n    <= '1;
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end
                end
                S_START: begin
                    // the engine samples eng_start on this enabled edge
                    r_eng_start <= 1'b0;
                    r_state     <= S_BUSY;
                end
                S_BUSY: begin
                    if (bus.eng_rdy) begin
                        r_rx_data <= bus.eng_rx;
                        r_done    <= r_gnt;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done <= '0;
                    if (w_lock_own) begin
                        r_state <= S_OWN;
                    end else begin
                        r_gnt     <= '0;
                        r_cs_n    <= '1;
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == CW'(DESEL - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.done      = r_done;
    assign bus.cs_n      = r_cs_n;
    assign bus.rx_data   = r_rx_data;
    assign bus.eng_tx    = r_eng_tx;
    assign bus.eng_start = r_eng_start;
    assign bus.eng_fast  = r_eng_fast;
endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter with a loopback SPI engine model.
module tb_spi_arbiter;
    localparam int NREQ  = 2;
    localparam int DESEL = 4;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic enable = 1'b0;

    always #5 clk = ~clk;

    spi_arbiter_if #(.NREQ(NREQ)) bus ();

    spi_arbiter #(.NREQ(NREQ), .DESEL(DESEL)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (bus)
    );

    // ---------------- loopback engine model (MOSI tied to MISO) ----------------
    logic        e_rdy;
    logic [5:0]  e_cnt;
    logic [31:0] e_sh;
    logic        e_f;
    logic [31:0] e_rx;
    int          e_starts;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_rdy    <= 1'b1;
            e_cnt    <= '0;
            e_sh     <= '0;
            e_f      <= 1'b0;
            e_rx     <= '0;
            e_starts <= 0;
        end else if (enable) begin
            if (e_rdy && bus.eng_start) begin
                e_rdy    <= 1'b0;
                e_cnt    <= bus.eng_fast ? 6'd32 : 6'd8;
                e_sh     <= bus.eng_tx;
                e_f      <= bus.eng_fast;
                e_starts <= e_starts + 1;
            end else if (!e_rdy) begin
                if (e_cnt == 6'd1) begin
                    e_rdy <= 1'b1;
                    e_rx  <= e_f ? e_sh : {24'h0, e_sh[7:0]};
                end
                e_cnt <= e_cnt - 6'd1;
            end
        end
    end

    assign bus.eng_rdy = e_rdy;
    assign bus.eng_rx  = e_rx;

    // ---------------- bookkeeping ----------------
    typedef struct {
        int          who;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] txq0[$];
    logic [31:0] txq1[$];

    int errors = 0;
    int checks = 0;

    logic [NREQ-1:0] prev_done;
    logic            prev_cs_high;
    logic            prev_start;
    logic [31:0]     exp_rx;
    int              hi_run;
    int              last_gap;
    int              n_grants;
    int              cyc_n;
    bit              throttle;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // queue a transfer for requester `who`; scoreboard order is the expected completion order
    task automatic xfer(input int who, input logic [31:0] data, input logic fast);
        exp_t x;
        x.who  = who;
        x.data = fast ? data : {24'h0, data[7:0]};
        sb.push_back(x);
        if (who == 0) begin
            txq0.push_back(data);
            if (!bus.req[0]) begin
                bus.tx_in[31:0] = data;
                bus.fast_in[0]  = fast;
                bus.req[0]      = 1'b1;
            end
        end else begin
            txq1.push_back(data);
            if (!bus.req[1]) begin
                bus.tx_in[63:32] = data;
                bus.fast_in[1]   = fast;
                bus.req[1]       = 1'b1;
            end
        end
    endtask

    // requester reaction to its done: next word or drop req (and lock)
    task automatic advance(input int who);
        if (who == 0) begin
            if (txq0.size() > 0) void'(txq0.pop_front());
            if (txq0.size() > 0) bus.tx_in[31:0] = txq0[0];
            else begin
                bus.req[0]  = 1'b0;
                bus.lock[0] = 1'b0;
            end
        end else begin
            if (txq1.size() > 0) void'(txq1.pop_front());
            if (txq1.size() > 0) bus.tx_in[63:32] = txq1[0];
            else begin
                bus.req[1]  = 1'b0;
                bus.lock[1] = 1'b0;
            end
        end
    endtask

    task automatic monitor(input logic e);
        logic [NREQ-1:0] inv_gnt;
        logic            cs_high;
        exp_t            x;
        inv_gnt = ~bus.gnt;
        cs_high = (bus.cs_n == '1);
        check_eq("cs_vs_gnt", bus.cs_n, inv_gnt);
        check_eq("gnt_onehot0", $onehot0(bus.gnt), 1);

        if (prev_cs_high && !cs_high) begin
            n_grants++;
            last_gap = hi_run;
        end
        if (!cs_high) hi_run = 0;
        else if (e) hi_run++;

        if (prev_start) begin
            if (!e) check_eq("start_hold", bus.eng_start, 1);
            else    check_eq("start_drop", bus.eng_start, 0);
        end

        if (bus.done != '0) begin
            if (prev_done != '0) begin
                check_eq("done_single", e, 0);
            end else begin
                check_eq("done_vs_gnt", bus.done, bus.gnt);
                if (sb.size() == 0) begin
                    check_eq("done_unexpected", bus.done, 0);
                end else begin
                    x = sb.pop_front();
                    check_eq("done_who", bus.done, oh(x.who));
                    check_eq("rx_data", bus.rx_data, x.data);
                    exp_rx = x.data;
                end
                if (bus.done[0]) advance(0);
                else             advance(1);
            end
        end else begin
            check_eq("rx_hold", bus.rx_data, exp_rx);
        end

        prev_done    = bus.done;
        prev_cs_high = cs_high;
        prev_start   = bus.eng_start;
    endtask

    task automatic cyc();
        logic e;
        if (throttle) enable = (cyc_n % 3 == 0);
        e = enable;
        @(posedge clk);
        #1;
        cyc_n++;
        monitor(e);
    endtask

    task automatic clear_tb();
        bus.req     = '0;
        bus.lock    = '0;
        bus.fast_in = '0;
        bus.tx_in   = '0;
        sb.delete();
        txq0.delete();
        txq1.delete();
    endtask

    task automatic resync();
        prev_done    = '0;
        prev_cs_high = 1'b1;
        prev_start   = 1'b0;
        exp_rx       = '0;
        hi_run       = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_tb();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        resync();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.req != '0) && n < budget) begin
            cyc();
            n++;
        end
        check_eq("drain_timeout", n < budget, 1);
        repeat (3 * (DESEL + 4)) cyc();
    endtask

    initial begin
        int g0;
        int n;
        clear_tb();
        throttle = 1'b0;
        cyc_n    = 0;
        n_grants = 0;
        last_gap = 0;
        resync();

        // ---- reset values ----
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_gnt",   bus.gnt,       0);
        check_eq("rst_done",  bus.done,      0);
        check_eq("rst_cs_n",  bus.cs_n,      2'b11);
        check_eq("rst_start", bus.eng_start, 0);
        check_eq("rst_fast",  bus.eng_fast,  0);
        check_eq("rst_tx",    bus.eng_tx,    0);
        check_eq("rst_rx",    bus.rx_data,   0);
        rst = 1'b1;
        enable = 1'b1;

        // ---- single slow transfer, then a re-request measuring the gap ----
        xfer(0, 32'h0000_00A5, 1'b0);
        cyc();
        check_eq("t1_gnt",  bus.gnt,  2'b01);
        check_eq("t1_cs_n", bus.cs_n, 2'b10);
        cyc();
        check_eq("t1_start", bus.eng_start, 1);
        check_eq("t1_tx",    bus.eng_tx,    32'h0000_00A5);
        check_eq("t1_fast",  bus.eng_fast,  0);
        n = 0;
        while (bus.done == '0 && n < 100) begin
            cyc();
            n++;
        end
        check_eq("t1_done_seen", n < 100, 1);
        xfer(0, 32'h0000_005A, 1'b0);
        cyc();
        check_eq("t1_release", bus.cs_n, 2'b11);
        drain(500);
        check_eq("t1_gap",    last_gap, DESEL + 1);
        check_eq("t1_starts", e_starts, 2);

        // ---- contention from reset ----
        do_reset();
        g0 = n_grants;
        xfer(0, 32'hCAFE_F00D, 1'b1);
        xfer(1, 32'h0000_003C, 1'b0);
        drain(500);
        check_eq("t2_grants", n_grants - g0, 2);
        check_eq("t2_gap",    last_gap, DESEL + 1);
        check_eq("t2_starts", e_starts, 2);

        // ---- locked sequence on requester 1, requester 0 arrives mid-way ----
        g0 = n_grants;
        n  = e_starts;
        bus.lock[1] = 1'b1;
        xfer(1, 32'h1122_3344, 1'b1);
        xfer(1, 32'h5566_7788, 1'b1);
        xfer(1, 32'h9ABC_DEF0, 1'b1);
        begin
            int k;
            k = 0;
            while (sb.size() > 2 && k < 200) begin
                cyc();
                k++;
            end
            check_eq("t3_first_done", k < 200, 1);
        end
        xfer(0, 32'h0000_00E7, 1'b0);
        drain(1000);
        check_eq("t3_grants", n_grants - g0, 2);
        check_eq("t3_starts", e_starts - n, 4);

        // ---- enable throttled 1-in-3; last owner is 0 so 1 goes first ----
        g0 = n_grants;
        n  = e_starts;
        throttle = 1'b1;
        xfer(1, 32'h1357_9BDF, 1'b1);
        xfer(0, 32'h2468_ACE0, 1'b1);
        drain(3000);
        throttle = 1'b0;
        enable   = 1'b1;
        check_eq("t4_grants", n_grants - g0, 2);
        check_eq("t4_gap",    last_gap, DESEL + 1);
        check_eq("t4_starts", e_starts - n, 2);

        // ---- round-robin fairness from reset with both requests held ----
        do_reset();
        g0 = n_grants;
        for (int unsigned k = 0; k < 4; k++) begin
            xfer(0, 32'hA000_0000 + k, 1'b1);
            xfer(1, 32'h0000_00B0 + k, 1'b0);
        end
        drain(2000);
        check_eq("t5_grants", n_grants - g0, 8);
        check_eq("t5_starts", e_starts, 8);

        // ---- reset asserted while the engine is busy ----
        xfer(1, 32'hDEAD_BEEF, 1'b1);
        n = 0;
        while (e_rdy && n < 20) begin
            cyc();
            n++;
        end
        check_eq("t6_busy_seen", n < 20, 1);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        check_eq("t6_cs_n",  bus.cs_n,      2'b11);
        check_eq("t6_gnt",   bus.gnt,       0);
        check_eq("t6_start", bus.eng_start, 0);
        check_eq("t6_done",  bus.done,      0);
        check_eq("t6_rx",    bus.rx_data,   0);
        clear_tb();
        @(posedge clk);
        #1;
        rst = 1'b1;
        resync();
        g0 = n_grants;
        xfer(1, 32'h0F1E_2D3C, 1'b1);
        drain(500);
        check_eq("t6_grants", n_grants - g0, 1);
        check_eq("t6_starts", e_starts, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Shares the single SPI transfer engine between NREQ requesters (SD card, flash, network) and owns their chip-selects. Each requester gets exclusive ownership of the engine for one transfer or a locked multi-transfer transaction. The arbiter drives the engine's start/fast/dataTx lines, collects the engine's received data and returns it to the owner. Selection is round-robin, and every release is followed by a programmable deselect gap.

## Interface
- NREQ, 2: number of requesters (2..4).
- DESEL, 4: chip-select deassert gap in enabled cycles (1..15).

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  clock enable shared with the SPI engine; the FSM advances only when high.
- req  in  NREQ  per-requester transfer request, level; held until the matching done.
- lock  in  NREQ  hold ownership after the current transfer.
- fast_in  in  NREQ  per-requester fast (32-bit) / slow (8-bit) select.
- tx_in  in  32*NREQ  per-requester transmit word; slice i is bits [32i+31:32i].
- gnt  out  NREQ  one-hot ownership indicator.
- done  out  NREQ  one-cycle pulse: transfer complete, rx_data valid.
- rx_data  out  32  last received word, held until the next done.
- cs_n  out  NREQ  active-low chip-selects, at most one low.
- eng_start, eng_fast  out  1  engine start and mode.
- eng_tx  out  32  engine transmit word.
- eng_rdy  in  1  engine ready.
- eng_rx  in  32  engine received data.

## Operation
- States: IDLE, OWN, START, BUSY, DONE, GAP.
- IDLE: if any req, pick a winner by round-robin, searching from (last owner + 1) mod NREQ. Set gnt and cs_n of the winner, then go to OWN. With no req, stay in IDLE.
- OWN, req[owner] high: latch tx_in slice and fast_in of the owner into eng_tx/eng_fast, assert eng_start, go to START.
- OWN, req[owner] low and lock[owner] low: go to GAP.
- START: hold eng_start high until a cycle with enable high, when the engine samples it. Then drop eng_start and go to BUSY.
- BUSY: wait for eng_rdy high on an enabled cycle, then go to DONE.
- DONE: capture eng_rx into rx_data and pulse done[owner] for one cycle. Go to OWN if lock[owner] is high, else to GAP.
- GAP: clear gnt, drive all cs_n high, and count DESEL enabled cycles. Then go to IDLE; the last-owner pointer keeps the released owner.
- Requests from non-owners are ignored until IDLE.
- eng_tx/eng_fast stay stable from START until the next START.
- Requester protocol: drop req on the edge ending its done cycle. A req seen in OWN after DONE is a new transfer.

## Timing
- Reset values: state IDLE, gnt 0, done 0, cs_n all 1, eng_start 0, eng_fast 0, eng_tx 0, rx_data 0, last-owner pointer NREQ-1 (so requester 0 wins first).
- All outputs are registered. With enable held high:
  - req to gnt/cs_n low: 1 cycle.
  - gnt to eng_start: 1 cycle (cs setup ≥ 1 cycle before the first SCLK).
  - eng_rdy high to done: 1 cycle.
  - done to cs_n high: 1 cycle when unlocked.
- While enable is low, all state, counters and outputs freeze; done stays a single pulse (the DONE state occupies one enabled cycle).
- Simultaneous requests: exactly one grant, round-robin; a requester that has just released loses to any other pending requester.
- lock dropped during BUSY: takes effect at DONE; release goes through GAP.
- lock high with no req: OWN holds indefinitely and cs stays asserted, by design.
- Reset asserted mid-transfer: immediate return to reset values; the engine shares rst and also resets.

## Test plan
- Single slow transfer: req[0]=1, fast_in[0]=0, tx slice 0 = 0x000000A5, engine loops MOSI to MISO. Expect gnt=01, cs_n=10, one eng_start, done[0] one pulse, rx_data=0x000000A5, cs_n=11 for DESEL=4 enabled cycles.
- Contention: req=11 in the same cycle from reset. Expect requester 0 first, then requester 1 after the gap, each with exactly one done; never both cs_n low.
- Locked sequence: lock[1]=1, three fast transfers 0x11223344, 0x55667788, 0x9ABCDEF0. Expect cs_n[1] low throughout with no GAP between them; req[0] raised mid-sequence is granted only after lock[1] drops.
- Enable throttling: enable toggles 1-in-3 during a fast transfer. Expect eng_start held until an enabled cycle, a single done pulse, correct rx_data, and the gap counted in enabled cycles only.
- Round-robin fairness: req=11 held continuously. Expect grants to alternate 0,1,0,1 over 8 transfers.
- Reset mid-BUSY: assert rst low during a transfer. Expect cs_n all 1, gnt 0 and eng_start 0 immediately; after release, a fresh req[1] completes normally.
